sprite_plotter: RTL and testbench



---
 rtl/sprite_plotter.sv | 159 +++++++++++++++
 tb/tb_sprite_plotter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_plotter.sv
// sprite_plotter: expands one sprite position into a SIZE x SIZE square of
// pixel writes for the VGA adapter, one pixel per clock. A new job starts
// only when idle and only when the {undraw, x, y} tuple has changed since
// the last accepted job (or nothing has been accepted since reset).
// Optional feature macro: SPRITE_PLOTTER_CLEAR_ON_RESET_EN -- when defined,
// the whole screen is swept with BG_COLOUR after every reset.
//
// state | meaning
// IDLE  | waiting for a changed position tuple
// PLOT  | sweeping the SIZE x SIZE square, dx inner, dy outer
// CLEAR | full-screen erase after reset (feature macro only)
module sprite_plotter #(
    parameter int         SIZE      = 4,
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int         X_MAX     = 160,
    parameter int         Y_MAX     = 120
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic       undraw_in,
    input  logic [2:0] colour_in,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy
);

`ifdef SPRITE_PLOTTER_CLEAR_ON_RESET_EN
    typedef enum logic [1:0] {S_IDLE, S_PLOT, S_CLEAR} state_t;
    localparam state_t RESET_STATE = S_CLEAR;
`else
    typedef enum logic [1:0] {S_IDLE, S_PLOT} state_t;
    localparam state_t RESET_STATE = S_IDLE;
`endif

    localparam logic [3:0] D_LAST = 4'(SIZE - 1);
    localparam logic [8:0] X_LIM  = 9'(X_MAX);
    localparam logic [7:0] Y_LIM  = 8'(Y_MAX);

    state_t      state, state_next;
    logic [15:0] tuple_q;
    logic        valid_q;
    logic [7:0]  x0_q;
    logic [6:0]  y0_q;
    logic [2:0]  col_q;
    logic [3:0]  dx_q, dy_q;

    logic [15:0] tuple_in;
    logic        request;
    logic [8:0]  px;
    logic [7:0]  py;
    logic        pix_on;
    logic        last_pix;

    assign tuple_in = {undraw_in, x_in, y_in};
    assign request  = !valid_q || (tuple_in != tuple_q);
    assign px       = {1'b0, x0_q} + {5'b0, dx_q};
    assign py       = {1'b0, y0_q} + {4'b0, dy_q};
    assign pix_on   = (px < X_LIM) && (py < Y_LIM);
    assign last_pix = (dx_q == D_LAST) && (dy_q == D_LAST);

`ifdef SPRITE_PLOTTER_CLEAR_ON_RESET_EN
    localparam logic [7:0] CX_LAST = 8'(X_MAX - 1);
    localparam logic [6:0] CY_LAST = 7'(Y_MAX - 1);
    logic [7:0] cx_q;
    logic [6:0] cy_q;
    logic       clear_last;
    assign clear_last = (cx_q == CX_LAST) && (cy_q == CY_LAST);
`endif

    // next-state decision
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (request) state_next = S_PLOT;
            S_PLOT:  if (last_pix) state_next = S_IDLE;
`ifdef SPRITE_PLOTTER_CLEAR_ON_RESET_EN
            S_CLEAR: if (clear_last) state_next = S_IDLE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // state register, job latch, sweep counters and registered pixel outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= RESET_STATE;
            tuple_q    <= '0;
            valid_q    <= 1'b0;
            x0_q       <= '0;
            y0_q       <= '0;
            col_q      <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
`ifdef SPRITE_PLOTTER_CLEAR_ON_RESET_EN
            cx_q       <= '0;
            cy_q       <= '0;
`endif
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    vga_plot <= 1'b0;
                    busy     <= 1'b0;
                    if (request) begin
                        x0_q    <= x_in;
                        y0_q    <= y_in;
                        col_q   <= undraw_in ? BG_COLOUR : colour_in;
                        tuple_q <= tuple_in;
                        valid_q <= 1'b1;
                        dx_q    <= '0;
                        dy_q    <= '0;
                    end
                end
                S_PLOT: begin
                    vga_x      <= px[7:0];
                    vga_y      <= py[6:0];
                    vga_colour <= col_q;
                    vga_plot   <= pix_on;
                    busy       <= 1'b1;
                    if (dx_q == D_LAST) begin
                        dx_q <= '0;
                        dy_q <= dy_q + 4'd1;
                    end else begin
                        dx_q <= dx_q + 4'd1;
                    end
                end
`ifdef SPRITE_PLOTTER_CLEAR_ON_RESET_EN
                S_CLEAR: begin
                    vga_x      <= cx_q;
                    vga_y      <= cy_q;
                    vga_colour <= BG_COLOUR;
                    vga_plot   <= 1'b1;
                    busy       <= 1'b1;
                    if (cx_q == CX_LAST) begin
                        cx_q <= '0;
                        cy_q <= cy_q + 7'd1;
                    end else begin
                        cx_q <= cx_q + 8'd1;
                    end
                end
`endif
                default: begin
                    vga_plot <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_plotter.sv
// Testbench for sprite_plotter (default build, clear feature disabled).
// Expected pixels come from a plain arithmetic model of the square sweep.
module tb_sprite_plotter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic       undraw_in;
    logic [2:0] colour_in;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    localparam int SZ = 4;

    sprite_plotter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .x_in       (x_in),
        .y_in       (y_in),
        .undraw_in  (undraw_in),
        .colour_in  (colour_in),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int x, input int y, input int u, input int c);
        x_in      = 8'(x);
        y_in      = 7'(y);
        undraw_in = 1'(u);
        colour_in = 3'(c);
    endtask

    // Bounded wait for busy to rise.
    task automatic wait_busy(input string tag);
        int n = 0;
        while (busy !== 1'b1 && n < 8) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(busy), 32'd1);
    endtask

    // Starting at the negedge where pixel 0 is visible, check the whole
    // square against the model, then check busy/plot dropped.
    task automatic sweep(input string tag, input int x, input int y, input int u,
                         input int c, output int nplot);
        int ex, ey, ecol;
        logic eplot;
        nplot = 0;
        ecol  = (u != 0) ? 0 : c;
        for (int k = 0; k < SZ * SZ; k++) begin
            ex    = x + (k % SZ);
            ey    = y + (k / SZ);
            eplot = (ex < 160) && (ey < 120);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_x"}, 32'(vga_x), 32'(ex & 255));
            chk({tag, "_y"}, 32'(vga_y), 32'(ey & 127));
            chk({tag, "_plot"}, 32'(vga_plot), 32'(eplot));
            if (eplot) chk({tag, "_colour"}, 32'(vga_colour), 32'(ecol));
            if (vga_plot === 1'b1) nplot++;
            @(negedge clock);
        end
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_plot_end"}, 32'(vga_plot), 32'd0);
    endtask

    initial begin
        int np, seen;
        int px, py, pu, nx, ny, nu, nc;

        reset_n = 1'b0;
        set_in(5, 5, 0, 3'b100);
        repeat (3) @(negedge clock);
        chk("rst_x", 32'(vga_x), 0);
        chk("rst_y", 32'(vga_y), 0);
        chk("rst_colour", 32'(vga_colour), 0);
        chk("rst_plot", 32'(vga_plot), 0);
        chk("rst_busy", 32'(busy), 0);

        // first job after reset
        reset_n = 1'b1;
        wait_busy("j1_start");
        sweep("j1", 5, 5, 0, 3'b100, np);
        chk("j1_count", np, 16);

        // erase same square, then redraw shifted up one row
        set_in(5, 5, 1, 3'b100);
        wait_busy("undraw_start");
        sweep("undraw", 5, 5, 1, 3'b100, np);
        chk("undraw_count", np, 16);
        set_in(5, 4, 0, 3'b100);
        wait_busy("row4_start");
        sweep("row4", 5, 4, 0, 3'b100, np);

        // colour-only change must not start a job
        colour_in = 3'b011;
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (busy !== 1'b0) seen++;
        end
        chk("colour_only", seen, 0);

        // clipping near the bottom-right corner
        set_in(158, 118, 0, 3'b010);
        wait_busy("clip_start");
        sweep("clip", 158, 118, 0, 3'b010, np);
        chk("clip_count", np, 4);

        // inputs changing while busy: only the last tuple is serviced
        set_in(9, 20, 0, 3'b101);
        wait_busy("skip_start");
        fork
            begin
                x_in = 8'd10;
                repeat (3) @(negedge clock);
                x_in = 8'd11;
                repeat (3) @(negedge clock);
                x_in = 8'd12;
            end
        join_none
        sweep("skip9", 9, 20, 0, 3'b101, np);
        @(negedge clock);
        chk("gap_one_idle", 32'(busy), 32'd1);
        sweep("skip12", 12, 20, 0, 3'b101, np);
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (busy !== 1'b0) seen++;
        end
        chk("no_extra_job", seen, 0);

        // reset in the middle of a job
        set_in(20, 30, 0, 3'b010);
        wait_busy("mid_start");
        repeat (6) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_plot", 32'(vga_plot), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_x", 32'(vga_x), 0);
        chk("midrst_colour", 32'(vga_colour), 0);
        reset_n = 1'b1;
        wait_busy("redraw_start");
        sweep("redraw", 20, 30, 0, 3'b010, np);
        chk("redraw_count", np, 16);

        // randomized jobs
        px = 20; py = 30; pu = 0;
        for (int i = 0; i < 8; i++) begin
            nx = $urandom_range(0, 255);
            ny = $urandom_range(0, 127);
            nu = $urandom_range(0, 1);
            nc = $urandom_range(0, 7);
            if (nx == px && ny == py && nu == pu) nu = 1 - nu;
            set_in(nx, ny, nu, nc);
            wait_busy("rnd_start");
            sweep("rnd", nx, ny, nu, nc, np);
            px = nx; py = ny; pu = nu;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
